// File: rtl/iic_pkg.sv
// ----------------------------------------------------------------------------
// iic_pkg -- shared definitions for the I2C register-access responder.
//   state_t  : protocol FSM states
//   ACK/NACK : SDA bit values of the acknowledge slot
//   ADDR_W   : device address width (7)
//   DATA_W   : data / register pointer width (8)
// ----------------------------------------------------------------------------
package iic_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

endpackage

// File: rtl/iic_sync_edge.sv
// ----------------------------------------------------------------------------
// iic_sync_edge -- 2-flop synchronizer with rise/fall detection for one
// asynchronous bus line. Flops reset to 1 so an idle (pulled-up) bus produces
// no spurious edge when reset releases.
//   clk_i      : system clock
//   reset_n_i  : asynchronous active-low reset
//   d_i        : asynchronous input line
//   q_o        : synchronized level
//   rise_o     : one-cycle pulse on a synchronized 0->1 transition
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition
// ----------------------------------------------------------------------------
module iic_sync_edge (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= d_i;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q_o    = sync;
  assign rise_o = sync & ~prev;
  assign fall_o = ~sync & prev;

endmodule

// File: rtl/iic_slave.sv
// ----------------------------------------------------------------------------
// iic_slave -- I2C responder giving a master byte-wide access to a register
// file: write = addr+W, reg pointer, data...; read = addr+R, data...
//   SLV_ADDR    : 7-bit device address
//   clk_i       : system clock (>= 8x SCL)
//   reset_n_i   : asynchronous active-low reset
//   scl_i/sda_i : bus lines, asynchronous to clk_i
//   sda_oe_o    : 1 pulls SDA low, 0 releases it
//   wr_en_o     : one-cycle strobe per written data byte
//   reg_addr_o  : register pointer
//   wr_data_o   : last written byte
//   rd_data_i   : register contents at reg_addr_o
//   busy_o      : high while this device is addressed (START .. STOP)
// Build option: define IIC_SLAVE_AUTOINC_EN to advance reg_addr_o after every
// written byte and after every read byte the master ACKs.
// ----------------------------------------------------------------------------
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLV_ADDR = 7'b1001011
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              busy_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  iic_sync_edge u_scl_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .d_i      (scl_i),
    .q_o      (scl),
    .rise_o   (scl_rise),
    .fall_o   (scl_fall)
  );

  iic_sync_edge u_sda_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .d_i      (sda_i),
    .q_o      (sda),
    .rise_o   (sda_rise),
    .fall_o   (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] rx_sr, rx_sr_n, tx_sr, tx_sr_n;
  logic [DATA_W-1:0] rx_shift;
  // In *_ACK states: 0 = waiting for the fall that starts the ACK slot,
  // 1 = ACK slot running. In RDATA_ACK: 1 = master ACKed, reload on next fall.
  logic              phase, phase_n;
  logic              rw, rw_n;
  logic              sda_oe_n, wr_en_n, busy_n;
  logic [DATA_W-1:0] reg_addr_n, wr_data_n;

  assign rx_shift = {rx_sr[DATA_W-2:0], sda};

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    rx_sr_n    = rx_sr;
    tx_sr_n    = tx_sr;
    phase_n    = phase;
    rw_n       = rw;
    sda_oe_n   = sda_oe_o;
    wr_en_n    = 1'b0;
    busy_n     = busy_o;
    reg_addr_n = reg_addr_o;
    wr_data_n  = wr_data_o;

`ifdef IIC_SLAVE_AUTOINC_EN
    // Advance one cycle after the strobe so the strobe sees the old pointer.
    if (wr_en_o) reg_addr_n = reg_addr_o + 8'd1;
`endif

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        IDLE: ;

        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            rx_sr_n   = rx_shift;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              phase_n = 1'b0;
              if (state == ADDR) begin
                if (rx_shift[DATA_W-1:1] == SLV_ADDR) begin
                  state_n = ADDR_ACK;
                  rw_n    = rx_shift[0];
                  busy_n  = 1'b1;
                end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                end
              end else if (state == REG) begin
                reg_addr_n = rx_shift;
                state_n    = REG_ACK;
              end else begin
                wr_data_n = rx_shift;
                wr_en_n   = 1'b1;
                state_n   = WDATA_ACK;
              end
            end
          end
        end

        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_n = ~ACK;
              phase_n  = 1'b1;
            end else begin
              phase_n   = 1'b0;
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              if (state == ADDR_ACK && rw) begin
                // Read: this fall both ends the ACK and presents the MSB.
                state_n  = RDATA;
                tx_sr_n  = rd_data_i;
                sda_oe_n = ~rd_data_i[DATA_W-1];
              end else if (state == ADDR_ACK) begin
                state_n = REG;
              end else begin
                state_n = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n  = 1'b0;
              state_n   = RDATA_ACK;
              bit_cnt_n = '0;
              phase_n   = 1'b0;
            end else begin
              tx_sr_n   = {tx_sr[DATA_W-2:0], 1'b0};
              sda_oe_n  = ~tx_sr[DATA_W-2];
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == NACK) begin
              state_n = IDLE;
            end else begin
              phase_n = 1'b1;
`ifdef IIC_SLAVE_AUTOINC_EN
              reg_addr_n = reg_addr_o + 8'd1;
`endif
            end
          end else if (scl_fall && phase) begin
            phase_n   = 1'b0;
            state_n   = RDATA;
            bit_cnt_n = '0;
            tx_sr_n   = rd_data_i;
            sda_oe_n  = ~rd_data_i[DATA_W-1];
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      phase      <= 1'b0;
      rw         <= 1'b0;
      sda_oe_o   <= 1'b0;
      wr_en_o    <= 1'b0;
      busy_o     <= 1'b0;
      reg_addr_o <= '0;
      wr_data_o  <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      rx_sr      <= rx_sr_n;
      tx_sr      <= tx_sr_n;
      phase      <= phase_n;
      rw         <= rw_n;
      sda_oe_o   <= sda_oe_n;
      wr_en_o    <= wr_en_n;
      busy_o     <= busy_n;
      reg_addr_o <= reg_addr_n;
      wr_data_o  <= wr_data_n;
    end
  end

endmodule
